// File: rtl/multiplier_taint_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_taint_pkg
//
// Shared definitions for the shift-add multiplier control slice with
// bit-precise taint tracking.
//   - state_e     : FSM state encoding (3 bits, IDLE = 0)
//   - ctrl_t      : bundle of the Moore control strobes
//   - CTRL_*      : per-state output-decode masks
//   - cnt_width() : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package multiplier_taint_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SUB   = 3'd4,
        ST_SHIFT = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Control strobes towards the datapath, MSB first.
    typedef struct packed {
        logic mdld;
        logic mrld;
        logic rsclear;
        logic rsload;
        logic rssub;
        logic rsshr;
        logic product_done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = 7'b000_0000;
    localparam ctrl_t CTRL_INIT  = 7'b111_0000;
    localparam ctrl_t CTRL_ADD   = 7'b000_1000;
    localparam ctrl_t CTRL_SUB   = 7'b000_0100;
    localparam ctrl_t CTRL_SHIFT = 7'b000_0010;
    localparam ctrl_t CTRL_DONE  = 7'b000_0001;

    // The counter only has to hold 0..width-1, so $clog2(width) bits are
    // enough; one bit is the floor so a 2-bit operand still gets a counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : multiplier_taint_pkg

// File: rtl/mult_taint_counter.sv
// -----------------------------------------------------------------------------
// mult_taint_counter
//
// Bit-position counter for the shift-add multiplier, with a single taint bit
// cnt_t describing how trustworthy the counter value is.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clr_i           load 0 into the counter and replace cnt_t with taint_i
//   inc_i           advance the counter by one (ignored while clr_i is high)
//   taint_merge_i   OR taint_i into cnt_t (ignored while clr_i is high)
//   taint_i         taint source (the FSM state taint)
//   cnt_o           current bit index, 0..WIDTH-1
//   cnt_t_o         taint of cnt_o
//   last_o          cnt_o == WIDTH-1
//   last_t_o        taint of last_o (same as cnt_t_o, the compare is on cnt)
// -----------------------------------------------------------------------------
module mult_taint_counter
    import multiplier_taint_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             taint_merge_i,
    input  logic             taint_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_t_o,
    output logic             last_o,
    output logic             last_t_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_t_q, cnt_t_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d   = cnt_q;
        cnt_t_d = cnt_t_q;
        if (clr_i) begin
            cnt_d   = '0;
            cnt_t_d = taint_i;
        end else begin
            if (inc_i) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (taint_merge_i) begin
                cnt_t_d = cnt_t_q | taint_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            cnt_t_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cnt_t_q <= cnt_t_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign cnt_t_o  = cnt_t_q;
    assign last_o   = (cnt_q == CNT_LAST);
    assign last_t_o = cnt_t_q;

endmodule : mult_taint_counter

// File: rtl/multiplier_control_taint_bitwise.sv
// -----------------------------------------------------------------------------
// multiplier_control_taint_bitwise
//
// Control FSM for a shift-add sequential multiplier with bit-precise taint.
// Sits between the start/productDone handshake and the multiplier datapath.
// Each multiplier bit costs TEST + SHIFT, plus ADD (or SUB on the MSB in
// two's-complement mode) when the bit is 1.
//
// Parameters
//   WIDTH   operand width, >= 2
//   SIGNED  1 = two's-complement, subtract the multiplicand on bit WIDTH-1
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start, start_t             begin a multiply / its taint
//   multiplierReg[_t]          multiplier register and its per-bit taint;
//                              must be held stable from INIT until DONE
//   busy, busy_t               operation in progress (any state but IDLE)
//   productDone, productDone_t one-cycle done pulse
//   mdld, mrld, rsclear        load multiplicand / multiplier, clear result
//   rsload, rssub, rsshr       add / subtract multiplicand, shift result right
//   *_t                        taint of each control output (= state taint)
// -----------------------------------------------------------------------------
module multiplier_control_taint_bitwise
    import multiplier_taint_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             busy,
    output logic             busy_t,
    output logic             productDone,
    output logic             productDone_t,
    output logic             mdld,
    output logic             mrld,
    output logic             rsclear,
    output logic             rsload,
    output logic             rssub,
    output logic             rsshr,
    output logic             mdld_t,
    output logic             mrld_t,
    output logic             rsclear_t,
    output logic             rsload_t,
    output logic             rssub_t,
    output logic             rsshr_t
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic             state_t_q, state_t_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_merge;
    logic [CNT_W-1:0] cnt;
    logic             cnt_t;
    logic             cnt_last;
    logic             cnt_last_t;

    logic             mr_bit;
    logic             mr_bit_t;
    ctrl_t            ctrl;

    // -------------------------------------------------------------------------
    // Bit counter and its taint
    // -------------------------------------------------------------------------
    mult_taint_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (cnt_clr),
        .inc_i         (cnt_inc),
        .taint_merge_i (cnt_merge),
        .taint_i       (state_t_q),
        .cnt_o         (cnt),
        .cnt_t_o       (cnt_t),
        .last_o        (cnt_last),
        .last_t_o      (cnt_last_t)
    );

    // Only the examined bit (and its own taint) feeds the branch decision.
    assign mr_bit   = multiplierReg[cnt];
    assign mr_bit_t = multiplierReg_t[cnt];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            state_t_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            state_t_q <= state_t_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, state taint and counter control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        state_t_d = state_t_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_merge = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Deciding not to start is itself influenced by start_t, so
                // the taint is absorbed whether or not start is high.
                state_t_d = state_t_q | start_t;
                if (start) begin
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                cnt_clr = 1'b1;
                state_d = ST_TEST;
            end

            ST_TEST: begin
                state_t_d = state_t_q | mr_bit_t | cnt_t;
                if (mr_bit) begin
                    state_d = (SIGNED && cnt_last) ? ST_SUB : ST_ADD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            ST_ADD, ST_SUB: begin
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                // The last-bit compare reads the counter, and the counter's
                // update is steered by the (possibly tainted) state.
                state_t_d = state_t_q | cnt_last_t;
                cnt_merge = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_TEST;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl = CTRL_NONE;
        unique case (state_q)
            ST_INIT:  ctrl = CTRL_INIT;
            ST_ADD:   ctrl = CTRL_ADD;
            ST_SUB:   ctrl = CTRL_SUB;
            ST_SHIFT: ctrl = CTRL_SHIFT;
            ST_DONE:  ctrl = CTRL_DONE;
            default:  ctrl = CTRL_NONE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign mdld        = ctrl.mdld;
    assign mrld        = ctrl.mrld;
    assign rsclear     = ctrl.rsclear;
    assign rsload      = ctrl.rsload;
    assign rssub       = ctrl.rssub;
    assign rsshr       = ctrl.rsshr;
    assign productDone = ctrl.product_done;

    // Every output is a function of the state alone, so each carries the
    // state taint, even while its value is 0.
    assign busy_t        = state_t_q;
    assign productDone_t = state_t_q;
    assign mdld_t        = state_t_q;
    assign mrld_t        = state_t_q;
    assign rsclear_t     = state_t_q;
    assign rsload_t      = state_t_q;
    assign rssub_t       = state_t_q;
    assign rsshr_t       = state_t_q;

endmodule : multiplier_control_taint_bitwise

// File: tb/tb_multiplier_control_taint_bitwise.sv
// -----------------------------------------------------------------------------
// tb_multiplier_control_taint_bitwise
//
// Three instances share clk/rst: u0 WIDTH=4 unsigned, u1 WIDTH=8 signed,
// u2 WIDTH=2 unsigned. Each cycle every instance's full output word
// {busy, mdld, mrld, rsclear, rsload, rssub, rsshr, productDone, 8 taints}
// is compared against a per-instance queue of expected words, pushed when an
// operation is launched. An empty queue means the instance should be IDLE.
// -----------------------------------------------------------------------------
module tb_multiplier_control_taint_bitwise;

    typedef enum int {K_IDLE, K_INIT, K_TEST, K_ADD, K_SUB, K_SHIFT, K_DONE} kind_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [3];
    logic       start_t [3];
    logic [7:0] mr      [3];
    logic [7:0] mr_t    [3];
    wire  [15:0] obs    [3];

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic        model_t [3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 2;
        localparam bit S = (g == 1);
        wire [15:0] o;
        multiplier_control_taint_bitwise #(
            .WIDTH  (W),
            .SIGNED (S)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start[g]),
            .start_t         (start_t[g]),
            .multiplierReg   (mr[g][W-1:0]),
            .multiplierReg_t (mr_t[g][W-1:0]),
            .busy            (o[15]),
            .mdld            (o[14]),
            .mrld            (o[13]),
            .rsclear         (o[12]),
            .rsload          (o[11]),
            .rssub           (o[10]),
            .rsshr           (o[9]),
            .productDone     (o[8]),
            .busy_t          (o[7]),
            .mdld_t          (o[6]),
            .mrld_t          (o[5]),
            .rsclear_t       (o[4]),
            .rsload_t        (o[3]),
            .rssub_t         (o[2]),
            .rsshr_t         (o[1]),
            .productDone_t   (o[0])
        );
        assign obs[g] = o;
    end

    function automatic int width_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 8 : 2;
    endfunction

    function automatic logic [15:0] exp_word(input kind_e k, input logic t);
        logic [7:0] c;
        case (k)
            K_INIT:  c = 8'b1111_0000;
            K_TEST:  c = 8'b1000_0000;
            K_ADD:   c = 8'b1000_1000;
            K_SUB:   c = 8'b1000_0100;
            K_SHIFT: c = 8'b1000_0010;
            K_DONE:  c = 8'b1000_0001;
            default: c = 8'b0000_0000;
        endcase
        return {c, {8{t}}};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [15:0] w);
        case (idx)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
    endfunction

    // One clock: sample #1 after the edge and compare all three instances.
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            e = exp_word(K_IDLE, model_t[i]);
            case (i)
                0:       if (q0.size() != 0) e = q0.pop_front();
                1:       if (q1.size() != 0) e = q1.pop_front();
                default: if (q2.size() != 0) e = q2.pop_front();
            endcase
            check($sformatf("u%0d cyc%0d", i, cyc), obs[i], e);
        end
    endtask

    // Expected cycle sequence of one multiply, from INIT to DONE, truncated
    // to 'limit' words; the sticky taint model is advanced to its end value.
    task automatic push_op(input int idx, input logic [7:0] m, input logic [7:0] mt,
                           input logic st_t, input int limit);
        logic [15:0] seq[$];
        int          w;
        bit          s;
        logic        t;
        w = width_of(idx);
        s = (idx == 1);
        t = model_t[idx] | st_t;
        seq.push_back(exp_word(K_INIT, t));
        for (int i = 0; i < w; i++) begin
            seq.push_back(exp_word(K_TEST, t));
            t = t | mt[i];
            if (m[i]) seq.push_back(exp_word((s && i == w - 1) ? K_SUB : K_ADD, t));
            seq.push_back(exp_word(K_SHIFT, t));
        end
        seq.push_back(exp_word(K_DONE, t));
        for (int j = 0; j < seq.size() && j < limit; j++) push(idx, seq[j]);
        model_t[idx] = t;
    endtask

    // Launch one multiply and clock until its expected words are consumed.
    // pulse_at > 0 re-pulses start that many cycles in (must be ignored);
    // hold keeps start high past DONE for a back-to-back launch.
    task automatic run_op(input int idx, input logic [7:0] m, input logic [7:0] mt,
                          input logic st_t, input int pulse_at, input bit hold);
        int n;
        mr[idx]      = m;
        mr_t[idx]    = mt;
        start[idx]   = 1'b1;
        start_t[idx] = st_t;
        push_op(idx, m, mt, st_t, 1000);
        tick();
        start_t[idx] = 1'b0;
        n = 1;
        while (qsize(idx) != 0 && n < 200) begin
            start[idx] = hold ? 1'b1 : (n == pulse_at);
            tick();
            n++;
        end
        if (qsize(idx) != 0) check($sformatf("u%0d drain", idx), 16'(qsize(idx)), 16'd0);
        if (!hold) start[idx] = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) model_t[i] = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i]   = 1'b0;
            start_t[i] = 1'b0;
            mr[i]      = 8'h00;
            mr_t[i]    = 8'h00;
            model_t[i] = 1'b0;
        end

        do_reset(2);
        tick();

        // WIDTH=4 counting: ADD at k+3 and k+8, done at k+12, no taint.
        run_op(0, 8'h05, 8'h00, 1'b0, 0, 1'b0);
        repeat (2) tick();

        // start pulsed mid-operation is ignored.
        run_op(0, 8'h05, 8'h00, 1'b0, 4, 1'b0);
        tick();

        // Signed: ADD on bit 0, SUB on bit 7, done at k+20.
        run_op(1, 8'h81, 8'h00, 1'b0, 0, 1'b0);
        tick();
        for (int r = 0; r < 4; r++) begin
            run_op(1, 8'($urandom_range(0, 255)), 8'h00, 1'b0, 0, 1'b0);
            tick();
        end

        // WIDTH=2, zero multiplier: done at k+6, no rsload/rssub.
        run_op(2, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        tick();

        // Bit-precise taint: only bit 3's taint, raised leaving its TEST.
        run_op(0, 8'h05, 8'h08, 1'b0, 0, 1'b0);
        repeat (2) tick();
        run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 0, 1'b0);
        tick();

        // rst and start together: rst wins, all taints cleared.
        start[2] = 1'b1;
        do_reset(1);
        start[2] = 1'b0;
        tick();

        // Tainted start, then back-to-back untainted run keeps the taint.
        run_op(1, 8'h81, 8'h00, 1'b1, 0, 1'b1);
        tick();
        run_op(1, 8'h81, 8'h00, 1'b0, 0, 1'b0);
        repeat (2) tick();

        // start_t with start low still taints the idle state.
        start_t[2] = 1'b1;
        model_t[2] = 1'b1;
        tick();
        start_t[2] = 1'b0;
        repeat (2) tick();

        do_reset(1);
        tick();

        // Abort during the SHIFT of bit 2: IDLE next cycle, no done pulse.
        mr[0]    = 8'h05;
        mr_t[0]  = 8'h00;
        start[0] = 1'b1;
        push_op(0, 8'h05, 8'h00, 1'b0, 9);
        tick();
        start[0] = 1'b0;
        repeat (8) tick();
        do_reset(1);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multiplier_control_taint_bitwise
